// File: rtl/coprocessor_pio_responder.sv
// -----------------------------------------------------------------------------
// coprocessor_pio_responder
//
// FPGA-side responder for the HPS-to-coprocessor PIO link. Detects a rising
// request bit on the instruction PIO and latches the opcode and payload. It
// issues the instruction to the matrix core with a valid/ready handshake and
// waits for the core's completion pulse. The result, or an error code, is then
// presented on the data-out / ready-signal PIOs until the ARM drops its request.
// A watchdog aborts an instruction that does not complete in time.
//
// Ports
//   i_clk            system clock (shared with the HPS PIO domain)
//   i_reset          synchronous, active-high reset
//   i_instr_in       [31] req, [30:28] opcode, [27:0] payload
//   o_data_out       result word or error code (1 reserved, 2 timeout, 3 core)
//   o_ready_signals  [0] done, [1] error
//   o_cop_valid      instruction valid to the core
//   o_cop_opcode     latched opcode
//   o_cop_payload    latched payload
//   i_cop_ready      core accepts the instruction
//   i_cop_done       single-cycle completion pulse
//   i_cop_error      qualifies i_cop_done as a failure
//   i_cop_result     result word, valid with i_cop_done
//   o_cop_abort      single-cycle pulse: core must drop the current instruction
// -----------------------------------------------------------------------------
module coprocessor_pio_responder #(
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int CNT_W          = 20
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [31:0] i_instr_in,
    output logic [31:0] o_data_out,
    output logic [1:0]  o_ready_signals,
    output logic        o_cop_valid,
    output logic [2:0]  o_cop_opcode,
    output logic [27:0] o_cop_payload,
    input  logic        i_cop_ready,
    input  logic        i_cop_done,
    input  logic        i_cop_error,
    input  logic [31:0] i_cop_result,
    output logic        o_cop_abort
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST     = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [2:0]       OP_RESERVED  = 3'b111;
    localparam logic [31:0]      ERR_RESERVED = 32'h0000_0001;
    localparam logic [31:0]      ERR_TIMEOUT  = 32'h0000_0002;
    localparam logic [31:0]      ERR_CORE     = 32'h0000_0003;

    state_t            r_state;
    logic              r_req_prev;
    logic [CNT_W-1:0]  r_cnt;
    logic [31:0]       r_data_out;
    logic [1:0]        r_ready;
    logic              r_valid;
    logic [2:0]        r_opcode;
    logic [27:0]       r_payload;
    logic              r_abort;

    state_t            w_state_next;
    logic [CNT_W-1:0]  w_cnt_next;
    logic [31:0]       w_data_next;
    logic [1:0]        w_ready_next;
    logic              w_valid_next;
    logic [2:0]        w_opcode_next;
    logic [27:0]       w_payload_next;
    logic              w_abort_next;

    logic              w_req;
    logic              w_accept;
    logic              w_expired;

    assign w_req     = i_instr_in[31];
    // Only a genuine 0->1 edge seen while idle starts an instruction.
    assign w_accept  = w_req && !r_req_prev && (r_state == S_IDLE);
    assign w_expired = (r_cnt == CNT_LAST);

    always_comb begin
        w_state_next   = r_state;
        w_cnt_next     = r_cnt;
        w_data_next    = r_data_out;
        w_ready_next   = r_ready;
        w_valid_next   = r_valid;
        w_opcode_next  = r_opcode;
        w_payload_next = r_payload;
        w_abort_next   = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_ready_next = 2'b00;
                w_valid_next = 1'b0;
                if (w_accept) begin
                    w_opcode_next  = i_instr_in[30:28];
                    w_payload_next = i_instr_in[27:0];
                    w_cnt_next     = '0;
                    if (i_instr_in[30:28] == OP_RESERVED) begin
                        w_state_next = S_ERR;
                        w_data_next  = ERR_RESERVED;
                        w_ready_next = 2'b10;
                    end else begin
                        w_state_next = S_ISSUE;
                        w_valid_next = 1'b1;
                    end
                end
            end

            S_ISSUE: begin
                w_cnt_next = r_cnt + 1'b1;
                // Completion pulses are meaningless before the handshake, so
                // the watchdog is the only competitor to cop_ready here.
                if (w_expired) begin
                    w_state_next = S_ERR;
                    w_valid_next = 1'b0;
                    w_abort_next = 1'b1;
                    w_data_next  = ERR_TIMEOUT;
                    w_ready_next = 2'b10;
                end else if (i_cop_ready) begin
                    w_state_next = S_WAIT;
                    w_valid_next = 1'b0;
                end
            end

            S_WAIT: begin
                w_cnt_next = r_cnt + 1'b1;
                // A completion on the expiry cycle still counts.
                if (i_cop_done) begin
                    if (i_cop_error) begin
                        w_state_next = S_ERR;
                        w_data_next  = ERR_CORE;
                        w_ready_next = 2'b10;
                    end else begin
                        w_state_next = S_DONE;
                        w_data_next  = i_cop_result;
                        w_ready_next = 2'b01;
                    end
                end else if (w_expired) begin
                    w_state_next = S_ERR;
                    w_abort_next = 1'b1;
                    w_data_next  = ERR_TIMEOUT;
                    w_ready_next = 2'b10;
                end
            end

            S_DONE, S_ERR: begin
                // data_out is left holding the last result/code.
                if (!w_req) begin
                    w_state_next = S_IDLE;
                    w_ready_next = 2'b00;
                end
            end

            default: begin
                w_state_next = S_IDLE;
                w_ready_next = 2'b00;
                w_valid_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= S_IDLE;
            r_req_prev <= 1'b1;   // a req held through reset must drop first
            r_cnt      <= '0;
            r_data_out <= '0;
            r_ready    <= 2'b00;
            r_valid    <= 1'b0;
            r_opcode   <= '0;
            r_payload  <= '0;
            r_abort    <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_req_prev <= w_req;
            r_cnt      <= w_cnt_next;
            r_data_out <= w_data_next;
            r_ready    <= w_ready_next;
            r_valid    <= w_valid_next;
            r_opcode   <= w_opcode_next;
            r_payload  <= w_payload_next;
            r_abort    <= w_abort_next;
        end
    end

    assign o_data_out      = r_data_out;
    assign o_ready_signals = r_ready;
    assign o_cop_valid     = r_valid;
    assign o_cop_opcode    = r_opcode;
    assign o_cop_payload   = r_payload;
    assign o_cop_abort     = r_abort;

endmodule
